control_unit: RTL and testbench
===============================

CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 clk  in  1  single clock; all state updates on rising edge.
REQ-002 rst_n  in  1  synchronous, active-low reset, sampled on rising clk.
REQ-003 opcode  in  6  instruction opcode field from instruction register.
REQ-004 executedInstr  in  32  full current instruction, used only for ERET detection (32'h42000018).
REQ-005 int_state  in  2  interrupt controller state: 00 idle, 01 request pending, 10 in service, 11 reserved (treated as idle).
REQ-006 int_respond  in  1  interrupt enable/acknowledge qualifier; entry is allowed only when 1.
REQ-007 outputs, all 1-bit: MemtoReg, RegDst, IorD, ALUSrcA, IRWrite, MemWrite, PCWrite, Branch, RegWrite.
REQ-008 ALUOp  out  2  00 add, 01 subtract, 10 decode funct.
REQ-009 ALUSrcB  out  2  00 regB, 01 constant 4, 10 SignImm, 11 SignImm<<2.
REQ-010 PCSrc  out  2  00 ALUResult, 01 ALUOut, 10 jump target, 11 special (vector or saved PC).
REQ-011 store_PC_REGFILE  out  2  00 none, 01 save PC/regfile context and select vector, 10 restore context and select saved PC.
REQ-012 current_state  out  4  present FSM state encoding.

Function
REQ-013 Moore FSM; every output is a function of current_state only; any signal not listed for a state is 0.
REQ-014 State encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXECUTE 6, ALUWB 7, BEQEX 8, ADDIEX 9, ADDIWB 10, JEX 11, INTSAVE 12, ERET 13; codes 14-15 go to FETCH on the next edge with all outputs 0.
REQ-015 FETCH: IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSrc=00, IRWrite=1, PCWrite=1; next DECODE.
REQ-016 DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00. Next state by opcode: 35 (lw) or 43 (sw) -> MEMADR; 0 (R-type) -> EXECUTE; 4 (beq) -> BEQEX; 8 (addi) -> ADDIEX; 2 (j) -> JEX; 16 with executedInstr==32'h42000018 -> ERET; any other -> FETCH.
REQ-017 MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00; next MEMRD if opcode==35, else MEMWR.
REQ-018 MEMRD: IorD=1; next MEMWB.
REQ-019 MEMWB: RegDst=0, MemtoReg=1, RegWrite=1; next completion (REQ-025).
REQ-020 MEMWR: IorD=1, MemWrite=1; next completion.
REQ-021 EXECUTE: ALUSrcA=1, ALUSrcB=00, ALUOp=10; next ALUWB. ALUWB: RegDst=1, MemtoReg=0, RegWrite=1; next completion.
REQ-022 BEQEX: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSrc=01, Branch=1; next completion.
REQ-023 ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUOp=00; next ADDIWB. ADDIWB: RegDst=0, MemtoReg=0, RegWrite=1; next completion.
REQ-024 JEX: PCSrc=10, PCWrite=1; next completion.
REQ-025 Completion: from MEMWB, MEMWR, ALUWB, BEQEX, ADDIWB, JEX, and from DECODE on an unsupported opcode, next state is INTSAVE if int_respond==1 and int_state==01, else FETCH.
REQ-026 INTSAVE: store_PC_REGFILE=01, PCSrc=11, PCWrite=1; next FETCH.
REQ-027 ERET: store_PC_REGFILE=10, PCSrc=11, PCWrite=1; next FETCH; no interrupt entry directly after ERET.
REQ-028 Interrupt requests never abort an instruction mid-sequence; int_state 10 or 11 blocks entry (no nesting).
REQ-029 Inputs are sampled only on the transition edge out of the deciding state; changes at other times have no effect.

Reset
REQ-030 rst_n==0 at a rising edge forces current_state to FETCH (0) on that edge, including mid-instruction, and it overrides every transition.
REQ-031 While held in reset, outputs show FETCH decoding. The first FETCH cycle after release is a normal fetch.

Verification
REQ-032 Reset, then opcode=35, int_respond=0 -> current_state 0,1,2,3,4,0; RegWrite=1 and MemtoReg=1 only in state 4.
REQ-033 opcode=43 -> 0,1,2,5,0; MemWrite=1 and IorD=1 in state 5 only.
REQ-034 opcode=0 -> 0,1,6,7,0 with ALUOp=10 in 6 and RegDst=1, RegWrite=1 in 7; opcode=4 -> 0,1,8,0 with Branch=1, ALUOp=01, PCSrc=01.
REQ-035 opcode=8, int_state=01, int_respond=1 -> 0,1,9,10,12,0; state 12 has store_PC_REGFILE=01, PCSrc=11, PCWrite=1. With int_respond=0 the sequence is 0,1,9,10,0.
REQ-036 opcode=16, executedInstr=32'h42000018 -> 0,1,13,0 with store_PC_REGFILE=10; opcode=63 -> 0,1,0.
REQ-037 rst_n driven low while in state 3 -> state 0 at the next edge; opcode=2 -> 0,1,11,0 with PCSrc=10, PCWrite=1.

Source files
------------

// File: rtl/control_unit.sv
// Multi-cycle MIPS-style control FSM with precise interrupt entry and ERET return.
// Control outputs are registered decodes of the state being entered, so they always match current_state.
module control_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [5:0]  opcode,
  input  logic [31:0] executedInstr,
  input  logic [1:0]  int_state,
  input  logic        int_respond,
  output logic        MemtoReg,
  output logic        RegDst,
  output logic        IorD,
  output logic        ALUSrcA,
  output logic        IRWrite,
  output logic        MemWrite,
  output logic        PCWrite,
  output logic        Branch,
  output logic        RegWrite,
  output logic [1:0]  ALUOp,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  PCSrc,
  output logic [1:0]  store_PC_REGFILE,
  output logic [3:0]  current_state
);

  localparam int unsigned STATE_W = 4;
  localparam int unsigned OP_W    = 6;

  localparam logic [OP_W-1:0] OP_RTYPE = OP_W'(0);
  localparam logic [OP_W-1:0] OP_J     = OP_W'(2);
  localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(4);
  localparam logic [OP_W-1:0] OP_ADDI  = OP_W'(8);
  localparam logic [OP_W-1:0] OP_COP0  = OP_W'(16);
  localparam logic [OP_W-1:0] OP_LW    = OP_W'(35);
  localparam logic [OP_W-1:0] OP_SW    = OP_W'(43);
  localparam logic [31:0]     ERET_INSTR = 32'h4200_0018;

  localparam logic [1:0] INT_PENDING = 2'b01;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BEQEX   = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JEX     = 4'd11,
    S_INTSAVE = 4'd12,
    S_ERET    = 4'd13,
    S_ILL14   = 4'd14,
    S_ILL15   = 4'd15
  } state_t;

  typedef struct packed {
    logic       mem_to_reg;
    logic       reg_dst;
    logic       ior_d;
    logic       alu_src_a;
    logic       ir_write;
    logic       mem_write;
    logic       pc_write;
    logic       branch;
    logic       reg_write;
    logic [1:0] alu_op;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic [1:0] store_ctx;
  } ctrl_t;

  state_t state_q;
  state_t state_n;
  state_t done_n;
  ctrl_t  ctrl_q;
  logic   int_take;

  // Moore output decode; anything not named for a state stays 0.
  function automatic ctrl_t decode(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.alu_src_b = 2'b01;
        c.ir_write  = 1'b1;
        c.pc_write  = 1'b1;
      end
      S_DECODE: c.alu_src_b = 2'b11;
      S_MEMADR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
      end
      S_MEMRD: c.ior_d = 1'b1;
      S_MEMWB: begin
        c.mem_to_reg = 1'b1;
        c.reg_write  = 1'b1;
      end
      S_MEMWR: begin
        c.ior_d     = 1'b1;
        c.mem_write = 1'b1;
      end
      S_EXECUTE: begin
        c.alu_src_a = 1'b1;
        c.alu_op    = 2'b10;
      end
      S_ALUWB: begin
        c.reg_dst   = 1'b1;
        c.reg_write = 1'b1;
      end
      S_BEQEX: begin
        c.alu_src_a = 1'b1;
        c.alu_op    = 2'b01;
        c.pc_src    = 2'b01;
        c.branch    = 1'b1;
      end
      S_ADDIEX: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
      end
      S_ADDIWB: c.reg_write = 1'b1;
      S_JEX: begin
        c.pc_src   = 2'b10;
        c.pc_write = 1'b1;
      end
      S_INTSAVE: begin
        c.store_ctx = 2'b01;
        c.pc_src    = 2'b11;
        c.pc_write  = 1'b1;
      end
      S_ERET: begin
        c.store_ctx = 2'b10;
        c.pc_src    = 2'b11;
        c.pc_write  = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  // Interrupts are only taken at an instruction boundary, and never while one is in service.
  assign int_take = int_respond && (int_state == INT_PENDING);

  always_comb begin
    done_n  = int_take ? S_INTSAVE : S_FETCH;
    state_n = S_FETCH;
    case (state_q)
      S_FETCH:  state_n = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_n = S_MEMADR;
          OP_RTYPE:     state_n = S_EXECUTE;
          OP_BEQ:       state_n = S_BEQEX;
          OP_ADDI:      state_n = S_ADDIEX;
          OP_J:         state_n = S_JEX;
          OP_COP0:      state_n = (executedInstr == ERET_INSTR) ? S_ERET : done_n;
          default:      state_n = done_n;
        endcase
      end
      S_MEMADR:  state_n = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:   state_n = S_MEMWB;
      S_EXECUTE: state_n = S_ALUWB;
      S_ADDIEX:  state_n = S_ADDIWB;
      S_MEMWB, S_MEMWR, S_ALUWB, S_BEQEX, S_ADDIWB, S_JEX:
                 state_n = done_n;
      S_INTSAVE, S_ERET:
                 state_n = S_FETCH;
      default:   state_n = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      ctrl_q  <= decode(S_FETCH);
    end else begin
      state_q <= state_n;
      ctrl_q  <= decode(state_n);
    end
  end

  assign current_state    = STATE_W'(state_q);
  assign MemtoReg         = ctrl_q.mem_to_reg;
  assign RegDst           = ctrl_q.reg_dst;
  assign IorD             = ctrl_q.ior_d;
  assign ALUSrcA          = ctrl_q.alu_src_a;
  assign IRWrite          = ctrl_q.ir_write;
  assign MemWrite         = ctrl_q.mem_write;
  assign PCWrite          = ctrl_q.pc_write;
  assign Branch           = ctrl_q.branch;
  assign RegWrite         = ctrl_q.reg_write;
  assign ALUOp            = ctrl_q.alu_op;
  assign ALUSrcB          = ctrl_q.alu_src_b;
  assign PCSrc            = ctrl_q.pc_src;
  assign store_PC_REGFILE = ctrl_q.store_ctx;

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: directed instruction table, reset corner case, then random instruction stream.
module tb_control_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [5:0]  opcode;
  logic [31:0] executedInstr;
  logic [1:0]  int_state;
  logic        int_respond;
  logic        MemtoReg, RegDst, IorD, ALUSrcA, IRWrite, MemWrite, PCWrite, Branch, RegWrite;
  logic [1:0]  ALUOp, ALUSrcB, PCSrc, store_PC_REGFILE;
  logic [3:0]  current_state;

  int checks = 0;
  int failures = 0;
  int exp_q[$];

  localparam logic [31:0] ERET_WORD = 32'h4200_0018;

  always #5 clk = ~clk;

  control_unit dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .executedInstr(executedInstr),
    .int_state(int_state), .int_respond(int_respond),
    .MemtoReg(MemtoReg), .RegDst(RegDst), .IorD(IorD), .ALUSrcA(ALUSrcA),
    .IRWrite(IRWrite), .MemWrite(MemWrite), .PCWrite(PCWrite), .Branch(Branch),
    .RegWrite(RegWrite), .ALUOp(ALUOp), .ALUSrcB(ALUSrcB), .PCSrc(PCSrc),
    .store_PC_REGFILE(store_PC_REGFILE), .current_state(current_state)
  );

  // {MemtoReg,RegDst,IorD,ALUSrcA,IRWrite,MemWrite,PCWrite,Branch,RegWrite,ALUOp,ALUSrcB,PCSrc,store}
  function automatic logic [16:0] expected_ctrl(input int s);
    logic m, rd, iod, sa, irw, mw, pcw, br, rw;
    logic [1:0] op, sb, ps, st;
    {m, rd, iod, sa, irw, mw, pcw, br, rw} = '0;
    {op, sb, ps, st} = '0;
    case (s)
      0:  begin sb = 2'b01; irw = 1; pcw = 1; end
      1:  sb = 2'b11;
      2:  begin sa = 1; sb = 2'b10; end
      3:  iod = 1;
      4:  begin m = 1; rw = 1; end
      5:  begin iod = 1; mw = 1; end
      6:  begin sa = 1; op = 2'b10; end
      7:  begin rd = 1; rw = 1; end
      8:  begin sa = 1; op = 2'b01; ps = 2'b01; br = 1; end
      9:  begin sa = 1; sb = 2'b10; end
      10: rw = 1;
      11: begin ps = 2'b10; pcw = 1; end
      12: begin st = 2'b01; ps = 2'b11; pcw = 1; end
      13: begin st = 2'b10; ps = 2'b11; pcw = 1; end
      default: ;
    endcase
    return {m, rd, iod, sa, irw, mw, pcw, br, rw, op, sb, ps, st};
  endfunction

  function automatic logic [16:0] actual_ctrl();
    return {MemtoReg, RegDst, IorD, ALUSrcA, IRWrite, MemWrite, PCWrite, Branch, RegWrite,
            ALUOp, ALUSrcB, PCSrc, store_PC_REGFILE};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic check_cycle(input string tag, input int s);
    check($sformatf("%s.state", tag), 32'(current_state), 32'(s));
    check($sformatf("%s.ctrl", tag), 32'(actual_ctrl()), 32'(expected_ctrl(s)));
  endtask

  // Whole-instruction reference: path through the machine, then optional interrupt entry.
  task automatic build_seq(input logic [5:0] op, input logic [31:0] instr,
                           input logic [1:0] ist, input logic resp);
    bit is_eret;
    exp_q = {0, 1};
    is_eret = 0;
    case (op)
      6'd35: exp_q = {exp_q, 2, 3, 4};
      6'd43: exp_q = {exp_q, 2, 5};
      6'd0:  exp_q = {exp_q, 6, 7};
      6'd4:  exp_q.push_back(8);
      6'd8:  exp_q = {exp_q, 9, 10};
      6'd2:  exp_q.push_back(11);
      6'd16: if (instr == ERET_WORD) begin exp_q.push_back(13); is_eret = 1; end
      default: ;
    endcase
    if (!is_eret && resp && ist == 2'b01) exp_q.push_back(12);
  endtask

  // Called just after a negedge with the DUT in FETCH; ends at the next FETCH.
  task automatic run_instr(input string tag, input logic [5:0] op, input logic [31:0] instr,
                           input logic [1:0] ist, input logic resp);
    opcode = op; executedInstr = instr; int_state = ist; int_respond = resp;
    for (int k = 0; k < exp_q.size(); k++) begin
      check_cycle($sformatf("%s.c%0d", tag, k), exp_q[k]);
      @(negedge clk);
    end
  endtask

  typedef struct {
    logic [5:0]  op;
    logic [31:0] instr;
    logic [1:0]  ist;
    logic        resp;
    int          len;
    logic [23:0] seq;
  } vec_t;

  vec_t vecs[13];

  initial begin
    vecs[0]  = '{6'd35, 32'h0, 2'b00, 1'b0, 5, 24'h012340};
    vecs[1]  = '{6'd43, 32'h0, 2'b00, 1'b0, 4, 24'h012500};
    vecs[2]  = '{6'd0,  32'h0, 2'b00, 1'b0, 4, 24'h016700};
    vecs[3]  = '{6'd4,  32'h0, 2'b00, 1'b0, 3, 24'h018000};
    vecs[4]  = '{6'd8,  32'h0, 2'b01, 1'b1, 5, 24'h019ac0};
    vecs[5]  = '{6'd8,  32'h0, 2'b01, 1'b0, 4, 24'h019a00};
    vecs[6]  = '{6'd16, ERET_WORD, 2'b01, 1'b1, 3, 24'h01d000};
    vecs[7]  = '{6'd63, 32'h0, 2'b00, 1'b0, 2, 24'h010000};
    vecs[8]  = '{6'd2,  32'h0, 2'b00, 1'b0, 3, 24'h01b000};
    vecs[9]  = '{6'd63, 32'h0, 2'b01, 1'b1, 3, 24'h01c000};
    vecs[10] = '{6'd35, 32'h0, 2'b10, 1'b1, 5, 24'h012340};
    vecs[11] = '{6'd0,  32'h0, 2'b01, 1'b1, 5, 24'h0167c0};
    vecs[12] = '{6'd16, 32'h0, 2'b11, 1'b1, 2, 24'h010000};

    rst_n = 1'b0; opcode = '0; executedInstr = '0; int_state = '0; int_respond = 1'b0;
    repeat (3) @(negedge clk);
    check_cycle("reset_hold", 0);
    rst_n = 1'b1;

    // Directed table
    for (int v = 0; v < 13; v++) begin
      exp_q = {};
      for (int k = 0; k < vecs[v].len; k++)
        exp_q.push_back(int'(vecs[v].seq[23 - 4*k -: 4]));
      run_instr($sformatf("vec%0d", v), vecs[v].op, vecs[v].instr, vecs[v].ist, vecs[v].resp);
    end
    check_cycle("after_table", 0);

    // Reset in MEMRD aborts the load; first fetch after release proceeds normally
    opcode = 6'd35; int_state = 2'b01; int_respond = 1'b1;
    for (int k = 0; k < 3; k++) @(negedge clk);
    check_cycle("rst_mid.memrd", 3);
    rst_n = 1'b0;
    @(negedge clk);
    check_cycle("rst_mid.forced", 0);
    @(negedge clk);
    check_cycle("rst_mid.held", 0);
    rst_n = 1'b1;
    opcode = 6'd2; int_state = 2'b00; int_respond = 1'b0;
    build_seq(6'd2, 32'h0, 2'b00, 1'b0);
    run_instr("post_rst_j", 6'd2, 32'h0, 2'b00, 1'b0);

    // Late input changes: int request raised only after the completion edge has passed
    build_seq(6'd4, 32'h0, 2'b00, 1'b0);
    opcode = 6'd4; int_state = 2'b00; int_respond = 1'b0;
    check_cycle("late.fetch", 0);
    @(negedge clk);
    check_cycle("late.decode", 1);
    @(negedge clk);
    check_cycle("late.beqex", 8);
    @(negedge clk);
    int_state = 2'b01; int_respond = 1'b1; opcode = 6'd35;
    check_cycle("late.fetch2", 0);
    @(negedge clk);
    check_cycle("late.decode2", 1);
    int_state = 2'b00; int_respond = 1'b0;
    @(negedge clk);
    check_cycle("late.memadr", 2);
    opcode = 6'd43;
    @(negedge clk);
    check_cycle("late.memwr", 5);
    @(negedge clk);
    check_cycle("late.fetch3", 0);

    // Random instruction stream against the reference
    for (int n = 0; n < 400; n++) begin
      logic [5:0]  op;
      logic [31:0] instr;
      logic [1:0]  ist;
      logic        resp;
      case ($urandom_range(0, 8))
        0: op = 6'd35;  1: op = 6'd43;  2: op = 6'd0;
        3: op = 6'd4;   4: op = 6'd8;   5: op = 6'd2;
        6: op = 6'd16;  7: op = 6'd63;
        default: op = 6'($urandom);
      endcase
      instr = ($urandom_range(0, 1) == 0) ? ERET_WORD : $urandom;
      ist   = 2'($urandom);
      resp  = 1'($urandom);
      build_seq(op, instr, ist, resp);
      run_instr($sformatf("rnd%0d", n), op, instr, ist, resp);
    end
    check_cycle("final", 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
